bit_serializer: RTL and testbench

Parallel-to-serial bit source feeding the serial sequence-detector FSM. Captures a code word from the switch/parallel bus and shifts out a programmable number of bits (1 to NBITS), one per clk_2 cycle, with valid/busy/done qualifiers. serial_out drives the detector's serial input (entrada), so patterns such as 4'b1101 can be replayed on demand.

---
 rtl/bit_serializer.sv | 158 +++++++++++++++
 tb/tb_bit_serializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial bit source for the serial sequence detector. A code
//   word is captured from data_in together with a bit count. Bits are then
//   shifted out on serial_out, one per clk_2 cycle. bit_valid, busy and done
//   qualify the stream.
//
//   Optional feature macro: SERIALIZER_LOOP_EN
//     When this macro is defined, the block gains a 'loop' input. It replays
//     the captured word continuously with no gap. done pulses on every wrap.
//
// Ports
//   clk_2      in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   start      in   load-and-send request, sampled only in IDLE
//   data_in    in   [NBITS-1:0] parallel word, captured on accept
//   len        in   [LW-1:0] bit count, clamped to NBITS, captured on accept
//   abort      in   cancels a transfer in progress (SHIFT only)
//   loop       in   (SERIALIZER_LOOP_EN only) replay the word at the last bit
//   serial_out out  current serial bit
//   bit_valid  out  serial_out carries a payload bit this cycle
//   busy       out  high in SHIFT and DONE
//   done       out  one-cycle pulse after the last bit
//   bit_index  out  [LW-1:0] 0-based position of the bit on serial_out
module bit_serializer #(
  parameter int NBITS     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int LW        = $clog2(NBITS + 1)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] data_in,
  input  logic [LW-1:0]    len,
  input  logic             abort,
`ifdef SERIALIZER_LOOP_EN
  input  logic             loop,
`endif
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    bit_index
);

  localparam logic [LW-1:0] NB  = LW'(NBITS);
  localparam logic [LW-1:0] ONE = LW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [NBITS-1:0]   r_word;
  logic [LW-1:0]      r_len;
  logic [LW-1:0]      r_index;
  logic               r_serial;
  logic               r_valid;
  logic               r_done;

  logic [LW-1:0]      w_eff_len;
  logic [LW-1:0]      w_next_idx;
  logic               w_first_bit;
  logic               w_next_bit;
  logic               w_wrap_bit;
  logic               w_last;
  logic               w_loop;

  // Bit i of an n-bit transfer: MSB-first walks data[n-1] down to data[0].
  function automatic logic bit_at(input logic [NBITS-1:0] w,
                                  input logic [LW-1:0]    n,
                                  input logic [LW-1:0]    i);
    logic [LW-1:0] pos;
    pos = MSB_FIRST ? (n - i - ONE) : i;
    return 1'(w >> pos);
  endfunction

  always_comb begin
    w_eff_len   = (len > NB) ? NB : len;
    w_first_bit = bit_at(data_in, w_eff_len, '0);
    w_next_idx  = r_index + ONE;
    w_next_bit  = bit_at(r_word, r_len, w_next_idx);
    w_wrap_bit  = bit_at(r_word, r_len, '0);
    w_last      = (r_index == (r_len - ONE));
`ifdef SERIALIZER_LOOP_EN
    w_loop      = loop;
`else
    w_loop      = 1'b0;
`endif
  end

  always_ff @(posedge clk_2) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_word   <= '0;
      r_len    <= '0;
      r_index  <= '0;
      r_serial <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && (len != '0)) begin
            r_state  <= SHIFT;
            r_word   <= data_in;
            r_len    <= w_eff_len;
            r_index  <= '0;
            // First bit goes straight out from the live bus so it appears
            // in the cycle right after the accepting edge.
            r_serial <= w_first_bit;
            r_valid  <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            r_state  <= IDLE;
            r_index  <= '0;
            r_serial <= 1'b0;
            r_valid  <= 1'b0;
          end else if (w_last) begin
            r_done <= 1'b1;
            if (w_loop) begin
              // Wrap: done pulses alongside bit 0 of the replayed word.
              r_index  <= '0;
              r_serial <= w_wrap_bit;
            end else begin
              r_state  <= DONE;
              r_index  <= '0;
              r_serial <= 1'b0;
              r_valid  <= 1'b0;
            end
          end else begin
            r_index  <= w_next_idx;
            r_serial <= w_next_bit;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_serial <= 1'b0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out = r_serial;
  assign bit_valid  = r_valid;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign bit_index  = r_index;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic       clk_2;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] len;
  logic       abort;
  logic       loop;

  logic       m_ser, m_val, m_busy, m_done;
  logic [3:0] m_idx;
  logic       l_ser, l_val, l_busy, l_done;
  logic [3:0] l_idx;

  int checks;
  int failures;

  bit_serializer #(.NBITS(8), .MSB_FIRST(1'b1)) u_msb (
    .clk_2(clk_2), .reset(reset), .start(start), .data_in(data_in),
    .len(len), .abort(abort),
`ifdef SERIALIZER_LOOP_EN
    .loop(loop),
`endif
    .serial_out(m_ser), .bit_valid(m_val), .busy(m_busy), .done(m_done),
    .bit_index(m_idx)
  );

  bit_serializer #(.NBITS(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk_2(clk_2), .reset(reset), .start(start), .data_in(data_in),
    .len(len), .abort(abort),
`ifdef SERIALIZER_LOOP_EN
    .loop(loop),
`endif
    .serial_out(l_ser), .bit_valid(l_val), .busy(l_busy), .done(l_done),
    .bit_index(l_idx)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  // Expected value packed as {serial_out, bit_valid, busy, done, bit_index}.
  task automatic chk_m(input string tag, input logic s, input logic v,
                       input logic b, input logic d, input logic [3:0] idx);
    logic [7:0] obs, exp;
    obs = {m_ser, m_val, m_busy, m_done, m_idx};
    exp = {s, v, b, d, idx};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL msb.%s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input logic s, input logic v,
                       input logic b, input logic d, input logic [3:0] idx);
    logic [7:0] obs, exp;
    obs = {l_ser, l_val, l_busy, l_done, l_idx};
    exp = {s, v, b, d, idx};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL lsb.%s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; start = 1'b0; data_in = '0; len = '0; abort = 1'b0;
    loop = 1'b0;

    // Reset for two cycles
    step(); step();
    chk_m("reset", 0, 0, 0, 0, 4'd0);
    chk_l("reset", 0, 0, 0, 0, 4'd0);
    reset = 1'b1;
    step();
    chk_m("idle", 0, 0, 0, 0, 4'd0);

    // Basic send 0x0D, len 4, MSB first: 1,1,0,1
    start = 1'b1; data_in = 8'h0D; len = 4'd4;
    step(); start = 1'b0; data_in = 8'h00;
    chk_m("basic_b0", 1, 1, 1, 0, 4'd0);
    chk_l("basic_b0", 1, 1, 1, 0, 4'd0);
    step(); chk_m("basic_b1", 1, 1, 1, 0, 4'd1);
    chk_l("basic_b1", 0, 1, 1, 0, 4'd1);
    step(); chk_m("basic_b2", 0, 1, 1, 0, 4'd2);
    step(); chk_m("basic_b3", 1, 1, 1, 0, 4'd3);
    step(); chk_m("basic_done", 0, 0, 1, 1, 4'd0);
    step(); chk_m("basic_idle", 0, 0, 0, 0, 4'd0);

    // LSB first with len clamped to 8: 0xA5 -> 1,0,1,0,0,1,0,1
    start = 1'b1; data_in = 8'hA5; len = 4'd15;
    step(); start = 1'b0;
    chk_l("clamp_b0", 1, 1, 1, 0, 4'd0);
    step(); chk_l("clamp_b1", 0, 1, 1, 0, 4'd1);
    step(); chk_l("clamp_b2", 1, 1, 1, 0, 4'd2);
    step(); chk_l("clamp_b3", 0, 1, 1, 0, 4'd3);
    step(); chk_l("clamp_b4", 0, 1, 1, 0, 4'd4);
    step(); chk_l("clamp_b5", 1, 1, 1, 0, 4'd5);
    step(); chk_l("clamp_b6", 0, 1, 1, 0, 4'd6);
    step(); chk_l("clamp_b7", 1, 1, 1, 0, 4'd7);
    step(); chk_l("clamp_done", 0, 0, 1, 1, 4'd0);
    step(); chk_l("clamp_idle", 0, 0, 0, 0, 4'd0);

    // start with len 0 is ignored
    start = 1'b1; data_in = 8'hFF; len = 4'd0;
    step(); start = 1'b0;
    chk_m("len0_a", 0, 0, 0, 0, 4'd0);
    chk_l("len0_a", 0, 0, 0, 0, 4'd0);
    step(); chk_m("len0_b", 0, 0, 0, 0, 4'd0);

    // start during SHIFT with new data is ignored
    start = 1'b1; data_in = 8'h0D; len = 4'd4;
    step(); chk_m("busy_b0", 1, 1, 1, 0, 4'd0);
    data_in = 8'hFF; len = 4'd8;
    step(); chk_m("busy_b1", 1, 1, 1, 0, 4'd1);
    step(); chk_m("busy_b2", 0, 1, 1, 0, 4'd2);
    step(); chk_m("busy_b3", 1, 1, 1, 0, 4'd3);
    start = 1'b0;
    step(); chk_m("busy_done", 0, 0, 1, 1, 4'd0);
    step(); chk_m("busy_idle", 0, 0, 0, 0, 4'd0);

    // Abort at bit_index 2
    start = 1'b1; data_in = 8'h0D; len = 4'd4;
    step(); start = 1'b0;
    step(); step(); chk_m("abort_mid_b2", 0, 1, 1, 0, 4'd2);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk_m("abort_mid_idle", 0, 0, 0, 0, 4'd0);
    step(); chk_m("abort_mid_nodone", 0, 0, 0, 0, 4'd0);

    // Abort together with the last bit
    start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step(); chk_m("abort_last_b3", 1, 1, 1, 0, 4'd3);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk_m("abort_last_idle", 0, 0, 0, 0, 4'd0);
    chk_l("abort_last_idle", 0, 0, 0, 0, 4'd0);
    step(); chk_m("abort_last_nodone", 0, 0, 0, 0, 4'd0);

    // Reset mid-transfer, then a normal 1-bit send
    start = 1'b1;
    step(); start = 1'b0;
    step(); chk_m("rst_mid_b1", 1, 1, 1, 0, 4'd1);
    reset = 1'b0;
    step(); chk_m("rst_mid", 0, 0, 0, 0, 4'd0);
    reset = 1'b1;
    step(); chk_m("rst_release", 0, 0, 0, 0, 4'd0);
    start = 1'b1; data_in = 8'h0D; len = 4'd1;
    step(); start = 1'b0;
    chk_m("len1_b0", 1, 1, 1, 0, 4'd0);
    step(); chk_m("len1_done", 0, 0, 1, 1, 4'd0);
    step(); chk_m("len1_idle", 0, 0, 0, 0, 4'd0);

`ifdef SERIALIZER_LOOP_EN
    // Continuous replay of 1101, then stop with a normal DONE
    loop = 1'b1; start = 1'b1; data_in = 8'h0D; len = 4'd4;
    step(); start = 1'b0;
    chk_m("loop_p0_b0", 1, 1, 1, 0, 4'd0);
    step(); chk_m("loop_p0_b1", 1, 1, 1, 0, 4'd1);
    step(); chk_m("loop_p0_b2", 0, 1, 1, 0, 4'd2);
    step(); chk_m("loop_p0_b3", 1, 1, 1, 0, 4'd3);
    step(); chk_m("loop_wrap_b0", 1, 1, 1, 1, 4'd0);
    step(); chk_m("loop_p1_b1", 1, 1, 1, 0, 4'd1);
    step(); chk_m("loop_p1_b2", 0, 1, 1, 0, 4'd2);
    step(); chk_m("loop_p1_b3", 1, 1, 1, 0, 4'd3);
    loop = 1'b0;
    step(); chk_m("loop_done", 0, 0, 1, 1, 4'd0);
    step(); chk_m("loop_idle", 0, 0, 0, 0, 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
